// File: rtl/spi_frame_bridge_if.sv
// Byte-level link between the spi_slave byte engine and the frame bridge.
// Latency: none, wires only.
// Backpressure: none; the host paces bytes, the bridge answers each byte event with one tx load.
interface spi_frame_bridge_if;
  logic       iFRAME_n;
  logic [7:0] iRX_DATA;
  logic       iRX_VALID;
  logic [7:0] oTX_DATA;
  logic       oTX_WREN;

  // Host / byte-engine side
  modport master (
    output iFRAME_n, iRX_DATA, iRX_VALID,
    input  oTX_DATA, oTX_WREN
  );

  // Bridge side
  modport slave (
    input  iFRAME_n, iRX_DATA, iRX_VALID,
    output oTX_DATA, oTX_WREN
  );
endinterface

// File: rtl/spi_frame_bridge.sv
// Frame assembler: header/payload/XOR checksum in, per-channel status snapshot streamed out, commit on valid frame end.
// Latency: frame start -> first tx load 3 cycles, byte event -> tx load 2 cycles, frame end -> commit 3 cycles.
// Backpressure: none; host paces bytes, rejected frames are counted and reported in the next flags byte.
module spi_frame_bridge #(
  parameter int NUM_CHANNELS = 6,
  parameter int CMD_BYTES    = 35,
  parameter int STATUS_BYTES = 78
) (
  input  logic                                  iCLK,
  input  logic                                  iRESETn,
  spi_frame_bridge_if.slave                     link,
  input  logic [NUM_CHANNELS*STATUS_BYTES*8-1:0] iSTATUS,
  output logic [NUM_CHANNELS*CMD_BYTES*8-1:0]    oCMD,
  output logic [NUM_CHANNELS-1:0]               oCMD_STROBE,
  output logic [15:0]                           oERR_COUNT
);

  localparam int SNAP_W    = STATUS_BYTES * 8;
  localparam int SHAD_W    = CMD_BYTES * 8;
  localparam int CNT_SAT_I = CMD_BYTES + STATUS_BYTES + 2;
  localparam int CW        = $clog2(CNT_SAT_I + 1);

  localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_SAT_I);
  localparam logic [CW-1:0] CNT_CMD  = CW'(CMD_BYTES);
  localparam logic [CW-1:0] CNT_STAT = CW'(STATUS_BYTES);
  localparam logic [6:0]    NCH      = 7'(NUM_CHANNELS);

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, CHECKSUM, TRAIL, COMMIT} state_t;

  state_t              state;
  logic                frame_s1, frame_s2, frame_s3;
  logic                rxv_q, rxv_prev;
  logic [7:0]          rx_q;
  logic [CW-1:0]       cnt;
  logic [7:0]          xor_acc;
  logic [6:0]          ch;
  logic                wr;
  logic                chk_got, chk_ok;
  logic                start_pend;
  logic [SNAP_W-1:0]   snap;
  logic [SHAD_W-1:0]   shadow;
  logic [7:0]          tx_data;
  logic                tx_wren;
  logic                last_chk, last_range, last_short;
  logic [4:0]          seq;

  logic                frame_fall, frame_rise, byte_evt;
  logic [SNAP_W-1:0]   hdr_status;
  logic [7:0]          next_tx;
  logic [CW-1:0]       cnt_inc;
  logic                err_short, err_range, err_chk;

  assign link.oTX_DATA = tx_data;
  assign link.oTX_WREN = tx_wren;

  assign frame_fall = frame_s3 & ~frame_s2;
  assign frame_rise = ~frame_s3 & frame_s2;
  assign byte_evt   = rxv_q & ~rxv_prev;
  assign cnt_inc    = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
  assign err_short  = ~chk_got;
  assign err_range  = (ch >= NCH);
  assign err_chk    = ~chk_ok;

  // Status of the channel named by the header byte currently on rx_q; unknown channels read as zero.
  always_comb begin
    hdr_status = '0;
    if (rx_q[6:0] < NCH)
      hdr_status = iSTATUS[int'(rx_q[6:0])*SNAP_W +: SNAP_W];
  end

  // Next status byte to stream back; zero-padded past the end of the snapshot.
  always_comb begin
    next_tx = 8'h00;
    if (cnt < CNT_STAT)
      next_tx = snap[int'(cnt)*8 +: 8];
  end

  // Two-flop synchroniser for the async frame line plus one delay flop for edge detection.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      frame_s1 <= 1'b1;
      frame_s2 <= 1'b1;
      frame_s3 <= 1'b1;
    end else begin
      frame_s1 <= link.iFRAME_n;
      frame_s2 <= frame_s1;
      frame_s3 <= frame_s2;
    end
  end

  // Register the byte-engine valid/data once and keep the previous valid for rising-edge detection.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      rxv_q    <= 1'b0;
      rxv_prev <= 1'b0;
      rx_q     <= 8'h00;
    end else begin
      rxv_q    <= link.iRX_VALID;
      rxv_prev <= rxv_q;
      rx_q     <= link.iRX_DATA;
    end
  end

  // Frame state machine: assembles the frame, streams status, and commits or rejects at frame end.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state       <= IDLE;
      cnt         <= '0;
      xor_acc     <= 8'h00;
      ch          <= 7'd0;
      wr          <= 1'b0;
      chk_got     <= 1'b0;
      chk_ok      <= 1'b0;
      start_pend  <= 1'b0;
      snap        <= '0;
      shadow      <= '0;
      tx_data     <= 8'h00;
      tx_wren     <= 1'b0;
      last_chk    <= 1'b0;
      last_range  <= 1'b0;
      last_short  <= 1'b0;
      seq         <= 5'd0;
      oERR_COUNT  <= 16'h0000;
      oCMD        <= '0;
      oCMD_STROBE <= '0;
    end else begin
      tx_wren     <= 1'b0;
      oCMD_STROBE <= '0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          xor_acc <= 8'h00;
          chk_got <= 1'b0;
          chk_ok  <= 1'b0;
          if (frame_fall || start_pend) begin
            start_pend <= 1'b0;
            tx_data    <= {last_chk, last_range, last_short, seq};
            tx_wren    <= 1'b1;
            state      <= HEADER;
          end
        end
        COMMIT: begin
          // A start landing in the commit cycle is remembered and served from IDLE.
          if (frame_fall)
            start_pend <= 1'b1;
          state <= IDLE;
        end
        default: begin
          if (frame_rise) begin
            if (err_short)
              {last_chk, last_range, last_short} <= 3'b001;
            else if (err_range)
              {last_chk, last_range, last_short} <= 3'b010;
            else if (err_chk)
              {last_chk, last_range, last_short} <= 3'b100;
            else begin
              {last_chk, last_range, last_short} <= 3'b000;
              if (wr) begin
                oCMD[int'(ch)*SHAD_W +: SHAD_W] <= shadow;
                oCMD_STROBE[ch]                  <= 1'b1;
              end
            end
            if ((err_short || err_range || err_chk) && (oERR_COUNT != 16'hFFFF))
              oERR_COUNT <= oERR_COUNT + 16'd1;
            seq   <= seq + 5'd1;
            state <= COMMIT;
          end else if (byte_evt) begin
            tx_wren <= 1'b1;
            case (state)
              HEADER: begin
                ch      <= rx_q[6:0];
                wr      <= rx_q[7];
                xor_acc <= rx_q;
                snap    <= hdr_status;
                tx_data <= hdr_status[7:0];
                cnt     <= CW'(1);
                state   <= PAYLOAD;
              end
              PAYLOAD: begin
                shadow[(int'(cnt)-1)*8 +: 8] <= rx_q;
                xor_acc <= xor_acc ^ rx_q;
                tx_data <= next_tx;
                cnt     <= cnt_inc;
                if (cnt == CNT_CMD)
                  state <= CHECKSUM;
              end
              CHECKSUM: begin
                chk_ok  <= (rx_q == xor_acc);
                chk_got <= 1'b1;
                tx_data <= next_tx;
                cnt     <= cnt_inc;
                state   <= TRAIL;
              end
              default: begin
                tx_data <= next_tx;
                cnt     <= cnt_inc;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_bridge.sv
// Randomised frame-level bench for spi_frame_bridge against a transaction model.
// Latency: checks start, per-byte and commit latencies against fixed cycle counts.
// Backpressure: none; bench paces bytes with generous gaps.
module tb_spi_frame_bridge;
  localparam int NCH = 6;
  localparam int CB  = 35;
  localparam int SB  = 78;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_frame_bridge_if link();

  logic [NCH*SB*8-1:0] status;
  logic [NCH*CB*8-1:0] cmd;
  logic [NCH-1:0]      strobe;
  logic [15:0]         err_count;

  spi_frame_bridge #(.NUM_CHANNELS(NCH), .CMD_BYTES(CB), .STATUS_BYTES(SB)) dut (
    .iCLK(clk), .iRESETn(rst_n), .link(link), .iSTATUS(status),
    .oCMD(cmd), .oCMD_STROBE(strobe), .oERR_COUNT(err_count)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: what the host should observe, kept at transaction level.
  logic [CB*8-1:0] m_cmd [NCH];
  logic [15:0]     m_err;
  logic [2:0]      m_flags;   // {chk, range, short}
  logic [4:0]      m_seq;

  logic [7:0] tx_log[$];

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Record every tx load the bridge hands to the byte engine.
  always @(negedge clk)
    if (rst_n && link.oTX_WREN) tx_log.push_back(link.oTX_DATA);

  function automatic logic [7:0] stat_byte(input int c, input int k);
    return status[(c*SB+k)*8 +: 8];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) m_cmd[c] = '0;
    m_err = 16'h0; m_flags = 3'b000; m_seq = 5'd0;
  endtask

  task automatic check_cmd();
    for (int c = 0; c < NCH; c++)
      check($sformatf("cmd_ch%0d", c), cmd[c*CB*8 +: CB*8], m_cmd[c]);
  endtask

  task automatic make_frame(input logic [7:0] hdr, input int nb, input bit good, output bq_t q);
    logic [7:0] x;
    q = {};
    q.push_back(hdr);
    for (int i = 1; i < nb; i++) q.push_back(8'($urandom));
    if (nb >= CB + 2) begin
      x = 8'h00;
      for (int i = 0; i <= CB; i++) x ^= q[i];
      q[CB+1] = good ? x : (x + 8'h01);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int lat = 0;
    @(posedge clk); #2;
    link.iRX_DATA = b;
    link.iRX_VALID = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (link.oTX_WREN && lat == 0) lat = i;
    end
    check("byte_lat", lat, 2);
    link.iRX_VALID = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic run_frame(input bq_t q);
    int nb = q.size();
    logic [7:0] hdr = q[0];
    int ch = int'(hdr[6:0]);
    bit wr = hdr[7];
    logic [7:0] exp_tx[$];
    logic [7:0] x;
    int lat = 0, n_strb = 0, s_lat = 0, multi = 0;
    logic [NCH-1:0] s_val = '0;
    bit sh, rg, bad, accept;

    exp_tx.push_back({m_flags, m_seq});
    for (int k = 0; k < nb; k++)
      exp_tx.push_back((ch < NCH && k < SB) ? stat_byte(ch, k) : 8'h00);
    tx_log.delete();

    @(posedge clk); #2;
    link.iFRAME_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (link.oTX_WREN && lat == 0) lat = i;
    end
    check("start_lat", lat, 3);

    for (int k = 0; k < nb; k++) send_byte(q[k]);

    @(posedge clk); #2;
    link.iFRAME_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (|strobe) begin
        n_strb++; s_lat = i; s_val = strobe;
        if ($countones(strobe) > 1) multi++;
      end
    end

    sh = (nb < CB + 2);
    rg = (ch >= NCH);
    x = 8'h00;
    bad = 1'b0;
    if (!sh) begin
      for (int i = 0; i <= CB; i++) x ^= q[i];
      bad = (q[CB+1] != x);
    end
    accept = 1'b0;
    if (sh)       m_flags = 3'b001;
    else if (rg)  m_flags = 3'b010;
    else if (bad) m_flags = 3'b100;
    else begin
      m_flags = 3'b000;
      if (wr) begin
        accept = 1'b1;
        for (int i = 0; i < CB; i++) m_cmd[ch][i*8 +: 8] = q[i+1];
      end
    end
    if ((sh || rg || bad) && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    m_seq = m_seq + 5'd1;

    check("tx_count", tx_log.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      check($sformatf("tx%0d", i), tx_log[i], exp_tx[i]);
    check("strobe_count", n_strb, accept ? 1 : 0);
    check("strobe_multi", multi, 0);
    if (accept) begin
      check("strobe_lat", s_lat, 3);
      check("strobe_val", s_val, NCH'(1) << ch);
    end
    check("err_count", err_count, m_err);
    check_cmd();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, limit 1000000 ns");
    $fatal(1);
  end

  initial begin
    bq_t q;
    logic [7:0] x;
    link.iFRAME_n = 1'b1;
    link.iRX_VALID = 1'b0;
    link.iRX_DATA = 8'h00;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < SB; k++)
        status[(c*SB+k)*8 +: 8] = (c == 4) ? 8'(8'hA0 + k) : 8'($urandom);
    model_reset();

    // Reset values
    repeat (3) @(posedge clk); #1;
    check("rst_wren", link.oTX_WREN, 1'b0);
    check("rst_txdata", link.oTX_DATA, 8'h00);
    check("rst_strobe", strobe, '0);
    check("rst_err", err_count, 16'h0);
    check_cmd();
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Write frame to channel 2, payload 0x01..0x23, good checksum
    q = {8'h82};
    for (int i = 1; i <= CB; i++) q.push_back(8'(i));
    x = 8'h00;
    for (int i = 0; i <= CB; i++) x ^= q[i];
    q.push_back(x);
    run_frame(q);

    // Status readback of channel 4, header plus 80 bytes, valid read-only frame
    make_frame(8'h04, 81, 1'b1, q);
    run_frame(q);

    // Bad checksum on channel 1
    make_frame(8'h81, CB + 2, 1'b0, q);
    run_frame(q);

    // Short frame: 10 bytes
    make_frame(8'h83, 10, 1'b1, q);
    run_frame(q);

    // Out-of-range channel 6
    make_frame(8'h86, CB + 2, 1'b1, q);
    run_frame(q);

    // Randomised frames
    for (int f = 0; f < 8; f++) begin
      int nb;
      logic [7:0] hdr;
      hdr = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7))};
      if ($urandom_range(0, 3) == 0) nb = $urandom_range(1, CB + 1);
      else                           nb = CB + 2 + $urandom_range(0, 45);
      make_frame(hdr, nb, $urandom_range(0, 3) != 0, q);
      run_frame(q);
    end

    // Reset in the middle of payload byte 20
    @(posedge clk); #2;
    link.iFRAME_n = 1'b0;
    repeat (8) @(posedge clk);
    send_byte(8'h81);
    for (int i = 1; i < 20; i++) send_byte(8'($urandom));
    @(posedge clk); #2;
    link.iRX_DATA = 8'h5A;
    link.iRX_VALID = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_wren", link.oTX_WREN, 1'b0);
    check("midrst_txdata", link.oTX_DATA, 8'h00);
    check("midrst_strobe", strobe, '0);
    check("midrst_err", err_count, 16'h0);
    check_cmd();
    link.iFRAME_n = 1'b1;
    link.iRX_VALID = 1'b0;
    repeat (3) @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    tx_log.delete();

    // Valid write to channel 0, then a read-only frame exposing seq
    make_frame(8'h80, CB + 2, 1'b1, q);
    run_frame(q);
    make_frame(8'h01, CB + 2, 1'b1, q);
    run_frame(q);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
